// File: rtl/lamp_pkg.sv
// lamp_pkg: shared definitions for the lamp actuator.
//   - lamp_state_e   : ramp FSM encoding (Off=0, RampUp=1, On=2, RampDown=3)
//   - DefaultPwmBits : default brightness / PWM counter width
//   - DefaultRampDiv : default clocks per brightness step
package lamp_pkg;

   localparam int unsigned DefaultPwmBits = 8;
   localparam int unsigned DefaultRampDiv = 4;

   typedef enum logic [1:0] {
      StOff      = 2'd0,
      StRampUp   = 2'd1,
      StOn       = 2'd2,
      StRampDown = 2'd3
   } lamp_state_e;

endpackage

// File: rtl/lamp_driver_if.sv
// lamp_driver_if: command / status bundle between the light controller and the lamp.
//   turn_lamp_on, turn_lamp_off : one-cycle command pulses (controller -> lamp)
//   lamp_pwm                    : PWM drive to the lamp
//   level                       : current brightness, 0..2^PWM_BITS-1
//   lampstate                   : 1 only while settled fully on
//   busy                        : 1 while ramping
//   ack                         : one-cycle pulse when a ramp completes
// master = controller side, slave = lamp side.
interface lamp_driver_if
   import lamp_pkg::*;
#(
   parameter int unsigned PWM_BITS = DefaultPwmBits
) ();

   logic                turn_lamp_on;
   logic                turn_lamp_off;
   logic                lamp_pwm;
   logic [PWM_BITS-1:0] level;
   logic                lampstate;
   logic                busy;
   logic                ack;

   modport master (
      output turn_lamp_on,
      output turn_lamp_off,
      input  lamp_pwm,
      input  level,
      input  lampstate,
      input  busy,
      input  ack
   );

   modport slave (
      input  turn_lamp_on,
      input  turn_lamp_off,
      output lamp_pwm,
      output level,
      output lampstate,
      output busy,
      output ack
   );

endinterface

// File: rtl/lamp_pwm_gen.sv
// lamp_pwm_gen: free-running PWM counter with a registered compare.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   i_level     : brightness to render, 0..MAX
//   o_lamp_pwm  : registered PWM output, lags i_level by one cycle
// Output is high while counter < level, forced high at level == MAX so full
// brightness has no one-count gap; level == 0 yields a constant 0.
module lamp_pwm_gen
   import lamp_pkg::*;
#(
   parameter int unsigned PWM_BITS = DefaultPwmBits
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PWM_BITS-1:0] i_level,
   output logic                o_lamp_pwm
);

   localparam logic [PWM_BITS-1:0] MaxLevel = {PWM_BITS{1'b1}};

   logic [PWM_BITS-1:0] r_cnt;
   logic                r_pwm;
   logic                w_pwm_next;

   assign w_pwm_next = (i_level == MaxLevel) || (r_cnt < i_level);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 1'b1;   // wraps MAX -> 0
         r_pwm <= w_pwm_next;
      end
   end

   assign o_lamp_pwm = r_pwm;

endmodule

// File: rtl/lamp_driver.sv
// lamp_driver: lamp actuator with soft brightness ramp.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   lamp_bus   : lamp_driver_if.slave (commands in; pwm/level/lampstate/busy/ack out)
// Parameters: PWM_BITS (level width, MAX = 2^PWM_BITS-1), RAMP_DIV (clocks per step, >= 1).
// Build option LAMP_DRIVER_SOFT_RAMP_EN: when defined, accepted commands ramp
// the level one step every RAMP_DIV clocks; when undefined, accepted commands
// jump straight to MAX / 0, busy is tied low and no prescaler is built.
// Off wins over a simultaneous on; redundant commands are ignored.
module lamp_driver
   import lamp_pkg::*;
#(
   parameter int unsigned PWM_BITS = DefaultPwmBits,
   parameter int unsigned RAMP_DIV = DefaultRampDiv
) (
   input  logic         clk,
   input  logic         reset,
   lamp_driver_if.slave lamp_bus
);

   localparam logic [PWM_BITS-1:0] MaxLevel = {PWM_BITS{1'b1}};

   if (RAMP_DIV < 1) begin : g_bad_ramp_div
      $error("lamp_driver: RAMP_DIV must be at least 1");
   end

   lamp_state_e         r_state, w_state_next;
   logic [PWM_BITS-1:0] r_level, w_level_next;
   logic                r_ack, w_ack_next;
   logic                r_lampstate;
   logic                w_off, w_on;
   logic                w_acc_off, w_acc_on;

   assign w_off = lamp_bus.turn_lamp_off;
   assign w_on  = lamp_bus.turn_lamp_on & ~w_off;   // off wins

   // Only commands that change direction are accepted.
   assign w_acc_off = w_off && ((r_state == StRampUp) || (r_state == StOn));
   assign w_acc_on  = w_on && ((r_state == StOff) || (r_state == StRampDown));

`ifdef LAMP_DRIVER_SOFT_RAMP_EN
   localparam int unsigned PrescW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [PrescW-1:0]   r_presc, w_presc_next;
   logic                w_presc_tc;
   logic [PWM_BITS-1:0] w_level_inc, w_level_dec;
   logic                r_busy;

   assign w_presc_tc  = (r_presc == PrescW'(RAMP_DIV - 1));
   assign w_level_inc = (r_level == MaxLevel) ? MaxLevel : r_level + 1'b1;
   assign w_level_dec = (r_level == '0) ? '0 : r_level - 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_level_next = r_level;
      w_ack_next   = 1'b0;
      w_presc_next = '0;   // idle and accepted commands restart the prescaler
      if (w_acc_off) begin
         w_state_next = StRampDown;
      end else if (w_acc_on) begin
         w_state_next = StRampUp;
      end else begin
         unique case (r_state)
            StRampUp: begin
               if (w_presc_tc) begin
                  w_level_next = w_level_inc;
                  if (w_level_inc == MaxLevel) begin
                     w_state_next = StOn;
                     w_ack_next   = 1'b1;
                  end
               end else begin
                  w_presc_next = r_presc + 1'b1;
               end
            end
            StRampDown: begin
               if (w_presc_tc) begin
                  w_level_next = w_level_dec;
                  if (w_level_dec == '0) begin
                     w_state_next = StOff;
                     w_ack_next   = 1'b1;
                  end
               end else begin
                  w_presc_next = r_presc + 1'b1;
               end
            end
            StOff, StOn: begin
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_presc <= w_presc_next;
         r_busy  <= (w_state_next == StRampUp) || (w_state_next == StRampDown);
      end
   end

   assign lamp_bus.busy = r_busy;
`else
   // Instant mode: only Off and On are ever reached.
   always_comb begin
      w_state_next = r_state;
      w_level_next = r_level;
      w_ack_next   = 1'b0;
      if (w_acc_off) begin
         w_state_next = StOff;
         w_level_next = '0;
         w_ack_next   = 1'b1;
      end else if (w_acc_on) begin
         w_state_next = StOn;
         w_level_next = MaxLevel;
         w_ack_next   = 1'b1;
      end
   end

   assign lamp_bus.busy = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StOff;
         r_level     <= '0;
         r_ack       <= 1'b0;
         r_lampstate <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_level     <= w_level_next;
         r_ack       <= w_ack_next;
         r_lampstate <= (w_state_next == StOn);
      end
   end

   lamp_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm_gen (
      .clk        (clk),
      .reset      (reset),
      .i_level    (r_level),
      .o_lamp_pwm (lamp_bus.lamp_pwm)
   );

   assign lamp_bus.level     = r_level;
   assign lamp_bus.ack       = r_ack;
   assign lamp_bus.lampstate = r_lampstate;

endmodule

// File: tb/tb_lamp_driver.sv
// tb_lamp_driver: directed + randomized bench for lamp_driver.
// A behavioural model (direction, tick count, level, PWM counter) predicts
// every output after each clock edge; all outputs are compared every cycle.
// Works for both builds of LAMP_DRIVER_SOFT_RAMP_EN.
module tb_lamp_driver;

   localparam int unsigned PwmBits = 8;
   localparam int unsigned RampDiv = 4;
   localparam int          Max     = (1 << PwmBits) - 1;
`ifdef LAMP_DRIVER_SOFT_RAMP_EN
   localparam bit Soft = 1'b1;
`else
   localparam bit Soft = 1'b0;
`endif

   logic clk;
   logic reset;

   lamp_driver_if #(.PWM_BITS(PwmBits)) u_if ();

   lamp_driver #(
      .PWM_BITS (PwmBits),
      .RAMP_DIV (RampDiv)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .lamp_bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Model state
   int m_level;
   int m_dir;     // +1 ramping up, -1 ramping down, 0 settled
   int m_tick;    // clocks since last accepted command or step
   bit m_lit;     // settled fully on
   bit m_ack;
   int m_cnt;     // PWM counter value
   bit m_pwm;

   task automatic model_reset();
      m_level = 0; m_dir = 0; m_tick = 0; m_lit = 1'b0;
      m_ack = 1'b0; m_cnt = 0; m_pwm = 1'b0;
   endtask

   task automatic model_edge(input bit on, input bit off);
      bit acc_on, acc_off;
      m_pwm = (m_level == Max) || (m_cnt < m_level);
      m_cnt = (m_cnt + 1) % (Max + 1);
      m_ack = 1'b0;
      acc_off = off && (m_dir == 1 || (m_dir == 0 && m_lit));
      acc_on  = !off && on && (m_dir == -1 || (m_dir == 0 && !m_lit));
`ifdef LAMP_DRIVER_SOFT_RAMP_EN
      if (acc_off) begin
         m_dir = -1; m_tick = 0; m_lit = 1'b0;
      end else if (acc_on) begin
         m_dir = 1; m_tick = 0; m_lit = 1'b0;
      end else if (m_dir != 0) begin
         m_tick++;
         if (m_tick == RampDiv) begin
            m_tick  = 0;
            m_level = m_level + m_dir;
            if (m_level > Max) m_level = Max;
            if (m_level < 0) m_level = 0;
            if ((m_dir == 1 && m_level == Max) || (m_dir == -1 && m_level == 0)) begin
               m_lit = (m_dir == 1);
               m_dir = 0;
               m_ack = 1'b1;
            end
         end
      end
`else
      if (acc_off) begin
         m_level = 0; m_lit = 1'b0; m_ack = 1'b1;
      end else if (acc_on) begin
         m_level = Max; m_lit = 1'b1; m_ack = 1'b1;
      end
`endif
   endtask

   task automatic check_all(input string tag);
      logic [PwmBits-1:0] exp_level;
      logic exp_busy, exp_ls;
      exp_level = PwmBits'(m_level);
      exp_busy  = (m_dir != 0);
      exp_ls    = (m_dir == 0) && m_lit;
      n_vec++;
      assert (u_if.level === exp_level) else begin
         n_bad++;
         $error("FAIL %s level: got %0d want %0d", tag, u_if.level, exp_level);
      end
      assert (u_if.busy === exp_busy) else begin
         n_bad++;
         $error("FAIL %s busy: got %b want %b", tag, u_if.busy, exp_busy);
      end
      assert (u_if.lampstate === exp_ls) else begin
         n_bad++;
         $error("FAIL %s lampstate: got %b want %b", tag, u_if.lampstate, exp_ls);
      end
      assert (u_if.ack === m_ack) else begin
         n_bad++;
         $error("FAIL %s ack: got %b want %b", tag, u_if.ack, m_ack);
      end
      assert (u_if.lamp_pwm === m_pwm) else begin
         n_bad++;
         $error("FAIL %s lamp_pwm: got %b want %b", tag, u_if.lamp_pwm, m_pwm);
      end
   endtask

   // Drive inputs for one clock, then check #1 after the edge.
   task automatic cycle(input bit on, input bit off, input string tag);
      u_if.turn_lamp_on  = on;
      u_if.turn_lamp_off = off;
      @(posedge clk);
      model_edge(on, off);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tag);
   endtask

   // Clocks from the command edge until ack; -1 if the bound expires.
   task automatic run_to_ack(input int bound, output int lat);
      lat = 0;
      while (u_if.ack !== 1'b1 && lat < bound) begin
         cycle(1'b0, 1'b0, "ramp");
         lat++;
      end
      if (u_if.ack !== 1'b1) lat = -1;
   endtask

   task automatic check_lat(input string tag, input int got, input int want);
      n_vec++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s ack latency: got %0d want %0d", tag, got, want);
      end
   endtask

   // Called #1 after an edge: reset lands mid-cycle, away from any edge.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #3;
      reset = 1'b0;
   endtask

   initial begin
      int lat;
      int l_at;
      int r;
      bit on, off;

      reset = 1'b1;
      u_if.turn_lamp_on  = 1'b0;
      u_if.turn_lamp_off = 1'b0;
      model_reset();
      #12;
      check_all("reset_state");
      reset = 1'b0;
      idle(5, "post_reset_idle");

      // Full ramp up from 0
      cycle(1'b1, 1'b0, "on_cmd");
      run_to_ack(1100, lat);
      check_lat("full_up", lat, Soft ? Max * RampDiv : 0);
      idle(260, "hold_max");

      // Redundant on while on
      cycle(1'b1, 1'b0, "redundant_on");
      idle(3, "redundant_on_idle");

      // Both commands while on: off wins, full ramp down
      cycle(1'b1, 1'b1, "both_in_on");
      run_to_ack(1100, lat);
      check_lat("full_down", lat, Soft ? Max * RampDiv : 0);
      idle(260, "hold_zero");

      // Both commands while off: ignored
      cycle(1'b1, 1'b1, "both_in_off");
      idle(5, "both_in_off_idle");

      // Off during ramp-up at level 100
      cycle(1'b1, 1'b0, "on_to_100");
      for (int i = 0; i < 500 && m_dir != 0 && m_level < 100; i++) cycle(1'b0, 1'b0, "to_100");
      l_at = m_level;
      cycle(1'b0, 1'b1, "off_at_100");
      run_to_ack(1100, lat);
      check_lat("down_from_100", lat, Soft ? l_at * RampDiv : 0);

      // Reversal: up, down part way, then up again
      cycle(1'b1, 1'b0, "rev_on");
      idle(200, "rev_up");
      cycle(1'b0, 1'b1, "rev_off");
      idle(40, "rev_down");
      l_at = m_level;
      cycle(1'b1, 1'b0, "rev_on2");
      run_to_ack(1100, lat);
      check_lat("reverse_up", lat, Soft ? (Max - l_at) * RampDiv : 0);

      // Asynchronous reset mid-ramp / while on
      cycle(1'b0, 1'b1, "pre_rst_off");
      idle(50, "pre_rst_ramp");
      do_reset("async_reset");
      idle(5, "post_async_reset");

      // Randomized command traffic
      for (int i = 0; i < 20000; i++) begin
         r   = int'($urandom_range(0, 299));
         on  = (r < 3) || (r == 6);
         off = (r >= 3 && r < 6) || (r == 6);
         cycle(on, off, "random");
         if ($urandom_range(0, 3999) == 0) do_reset("random_reset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
